// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/AbsoluteValue.sv
// Two's-complement magnitude; the most negative input maps to 2^(W-1) read as unsigned.
module AbsoluteValue #(
  parameter int l = 16
) (
  input  logic [l-1:0] val_i,
  output logic [l-1:0] mag_o
);

  assign mag_o = val_i[l-1] ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/GiveSign.sv
// Applies a sign to an unsigned magnitude by conditional two's-complement negation.
module GiveSign #(
  parameter int l = 16
) (
  input  logic [l-1:0] mag_i,
  input  logic         neg_i,
  output logic [l-1:0] val_o
);

  assign val_o = neg_i ? (~mag_i + 1'b1) : mag_i;

endmodule

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module seq_divider_div_step #(
  parameter int l = 16
) (
  input  logic [l:0]   rem_i,
  input  logic         msb_i,
  input  logic [l-1:0] dvs_i,
  output logic [l:0]   rem_o,
  output logic         qbit_o
);

  logic [l:0] shifted;
  logic       ge;

  assign shifted = {rem_i[l-1:0], msb_i};
  // A set top bit means the shifted value already exceeds any l-bit divisor.
  assign ge      = rem_i[l] | (shifted >= {1'b0, dvs_i});
  assign rem_o   = ge ? (shifted - {1'b0, dvs_i}) : shifted;
  assign qbit_o  = ge;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: magnitude capture, l restoring steps, then sign fix-up.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int l = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic         Signed,
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [l-1:0] Q,
  output logic [l-1:0] R,
  output logic         DivZero
);

  localparam int CW = cnt_width(l);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [l:0]    rem_q, rem_d;
  logic [l-1:0]  dvd_q, dvd_d;
  logic [l-1:0]  dvs_q, dvs_d;
  logic [l-1:0]  araw_q, araw_d;
  logic          qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [l-1:0]  q_q, q_d, r_q, r_d;
  logic          divzero_q, divzero_d, done_q, done_d;

  logic [l-1:0]  abs_a, abs_b, sgn_q, sgn_r;
  logic [l:0]    step_rem;
  logic          step_qbit;

  AbsoluteValue #(.l(l)) u_abs_a (.val_i(A), .mag_o(abs_a));
  AbsoluteValue #(.l(l)) u_abs_b (.val_i(B), .mag_o(abs_b));

  seq_divider_div_step #(.l(l)) u_step (
    .rem_i  (rem_q),
    .msb_i  (dvd_q[l-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  GiveSign #(.l(l)) u_sgn_q (.mag_i(dvd_q),        .neg_i(qneg_q), .val_o(sgn_q));
  GiveSign #(.l(l)) u_sgn_r (.mag_i(rem_q[l-1:0]), .neg_i(rneg_q), .val_o(sgn_r));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    araw_d    = araw_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    q_d       = q_q;
    r_d       = r_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          dvd_d   = Signed ? abs_a : A;
          dvs_d   = Signed ? abs_b : B;
          qneg_d  = Signed & (A[l-1] ^ B[l-1]);
          rneg_d  = Signed & A[l-1];
          dz_d    = (B == '0);
          araw_d  = A;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // The dividend register fills with quotient bits as it shifts out.
        rem_d = step_rem;
        dvd_d = {dvd_q[l-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(l - 1)) state_d = SIGN;
      end
      SIGN: begin
        if (dz_q) begin
          q_d       = '1;
          r_d       = araw_q;
          divzero_d = 1'b1;
        end else begin
          q_d       = sgn_q;
          r_d       = sgn_r;
          divzero_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      araw_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      araw_q    <= araw_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      q_q       <= q_d;
      r_q       <= r_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Q       = q_q;
  assign R       = r_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operations, latency, busy and reset behaviour.
module tb_seq_divider;

  localparam int L = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic          Signed;
  logic [L-1:0]  A, B;
  logic          Busy, Done, DivZero;
  logic [L-1:0]  Q, R;

  typedef struct {
    logic [L-1:0] q;
    logic [L-1:0] r;
    logic         dz;
    int           k;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  seq_divider #(.l(L)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .Signed  (Signed),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Q       (Q),
    .R       (R),
    .DivZero (DivZero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Q", 32'(Q), 32'(e.q));
        chk("R", 32'(R), 32'(e.r));
        chk("DivZero", 32'(DivZero), 32'(e.dz));
        chk("latency", 32'(edge_cnt - e.k), 32'(L + 1));
        chk("busy_in_done", 32'(Busy), 32'd0);
      end
    end
  end

  // Caller positions at a negedge; Start is sampled at the following posedge.
  task automatic issue(input logic s, input logic [L-1:0] a, input logic [L-1:0] b,
                       input logic [L-1:0] eq, input logic [L-1:0] er, input logic edz,
                       input bit expect_done);
    exp_t e;
    Signed = s; A = a; B = b; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    if (expect_done) begin
      e.q = eq; e.r = er; e.dz = edz; e.k = edge_cnt;
      sb.push_back(e);
    end
    chk("busy_after_start", 32'(Busy), 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (Done === 1'b1) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic s, input logic [L-1:0] a, input logic [L-1:0] b,
                     input logic [L-1:0] eq, input logic [L-1:0] er, input logic edz);
    @(negedge clk);
    issue(s, a, b, eq, er, edz, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_dz", 32'(DivZero), 32'd0);
    reset = 1'b0;

    // -7 / 2 with busy still high in the last SIGN cycle
    @(negedge clk);
    issue(1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    chk("busy_last_cycle", 32'(Busy), 32'd1);
    wait_done();

    run(1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0);
    run(1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);
    run(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    run(1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0);
    run(1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0);
    run(1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    run(1'b0, 16'hABCD, 16'h0000, 16'hFFFF, 16'hABCD, 1'b1);

    // Start while busy is ignored; Start in the Done cycle is accepted
    @(negedge clk);
    issue(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    Signed = 1'b0; A = 16'd50; B = 16'd5; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_done();
    issue(1'b0, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b1);
    wait_done();

    // Reset mid-operation: no result ever appears for the aborted divide
    @(negedge clk);
    issue(1'b0, 16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_q", 32'(Q), 32'd0);
    chk("abort_r", 32'(R), 32'd0);
    repeat (30) @(negedge clk);
    run(1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
